// File: rtl/aes_inv_round_mix.sv
// AES decryption round datapath: InvShiftRows, AddRoundKey, then column-serial
// InvMixColumns (skipped on the final round) under a valid/ready handshake.
module aes_inv_round_mix #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state,
  input  logic [127:0] roundkey,
  input  logic         last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] result,
  output logic         busy
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] Step    = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LastCol = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} fsm_e;

  fsm_e         fsm_q;
  logic [127:0] work_q, work_d;
  logic [127:0] shifted;
  logic [1:0]   col_q;
  logic         last_q;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4], mb [4], md [4], me [4];
    logic [7:0] x2, x4, x8;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      x2    = xtime(a[r]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[r] = x8 ^ a[r];
      mb[r] = x8 ^ x2 ^ a[r];
      md[r] = x8 ^ x4 ^ a[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Row r of column c takes the byte from column (c - r) mod 4.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127-8*(4*c+r) -: 8] = state[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
  end

  always_comb begin
    work_d = work_q;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      work_d[32*(3-int'(col_q)-k) +: 32] =
          last_q ? work_q[32*(3-int'(col_q)-k) +: 32]
                 : inv_mix_col(work_q[32*(3-int'(col_q)-k) +: 32]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q  <= StIdle;
      work_q <= '0;
      col_q  <= '0;
      last_q <= 1'b0;
    end else begin
      unique case (fsm_q)
        StIdle, StDone: begin
          if (in_valid && in_ready) begin
            work_q <= shifted ^ roundkey;
            last_q <= last;
            col_q  <= '0;
            fsm_q  <= StBusy;
          end else if (fsm_q == StDone && out_ready) begin
            fsm_q <= StIdle;
          end
        end
        StBusy: begin
          work_q <= work_d;
          col_q  <= col_q + Step;
          if (col_q == LastCol) fsm_q <= StDone;
        end
        default: fsm_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (fsm_q == StIdle) || (fsm_q == StDone && out_ready);
  assign out_valid = (fsm_q == StDone);
  assign busy      = (fsm_q != StIdle);
  assign result    = work_q;

endmodule

// File: tb/tb_aes_inv_round_mix.sv
// Bench for aes_inv_round_mix: three instances (1, 2, 4 columns per cycle) checked
// against a byte-level AES inverse-round model.
module tb_aes_inv_round_mix;
  localparam int NDUT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid  [NDUT];
  logic         in_ready  [NDUT];
  logic         last      [NDUT];
  logic         out_valid [NDUT];
  logic         out_ready [NDUT];
  logic         busy      [NDUT];
  logic [127:0] state     [NDUT];
  logic [127:0] roundkey  [NDUT];
  logic [127:0] result    [NDUT];

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    aes_inv_round_mix #(.COLS_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .state    (state[g]),
      .roundkey (roundkey[g]),
      .last     (last[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .result   (result[g]),
      .busy     (busy[g])
    );
  end

  function automatic int latency_of(input int d);
    return 4 / (1 << d);
  endfunction

  // Generic shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in, b = b_in, p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] st, input logic [127:0] key,
                                         input logic lst);
    logic [7:0]   s [16], k [16], t [16], o [16];
    logic [7:0]   coef [4];
    logic [127:0] res;
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int i = 0; i < 16; i++) begin
      s[i] = st[127-8*i -: 8];
      k[i] = key[127-8*i -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[4*c+r] = s[4*((c-r+4)%4)+r] ^ k[4*c+r];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        o[4*c+r] = 8'h00;
        for (int j = 0; j < 4; j++) o[4*c+r] = o[4*c+r] ^ gmul(coef[(j-r+4)%4], t[4*c+j]);
        if (lst) o[4*c+r] = t[4*c+r];
      end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = o[i];
    return res;
  endfunction

  task automatic accept(input int d, input logic [127:0] st, input logic [127:0] key,
                        input logic lst);
    int n = 0;
    while (!in_ready[d] && n < 32) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (in_ready[d] !== 1'b1) begin
      failures++;
      $display("FAIL accept_ready dut%0d: in_ready=%b required 1", d, in_ready[d]);
    end
    in_valid[d] = 1'b1; state[d] = st; roundkey[d] = key; last[d] = lst;
    @(posedge clk); #1;
    in_valid[d] = 1'b0; state[d] = $urandom; roundkey[d] = $urandom; last[d] = $urandom;
  endtask

  task automatic wait_out(input int d, output int n);
    n = 0;
    while (!out_valid[d] && n < 32) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic consume(input int d);
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    checks++;
    if (out_valid[d] !== 1'b0 || busy[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
      failures++;
      $display("FAIL consume dut%0d: out_valid=%b busy=%b in_ready=%b required 0 0 1",
               d, out_valid[d], busy[d], in_ready[d]);
    end
  endtask

  task automatic run_txn(input int d, input logic [127:0] st, input logic [127:0] key,
                         input logic lst, input logic [127:0] exp);
    int n;
    accept(d, st, key, lst);
    wait_out(d, n);
    checks++;
    if (n !== latency_of(d)) begin
      failures++;
      $display("FAIL latency dut%0d: got %0d required %0d", d, n, latency_of(d));
    end
    checks++;
    if (result[d] !== exp) begin
      failures++;
      $display("FAIL result dut%0d last=%b: got %h required %h", d, lst, result[d], exp);
    end
    consume(d);
  endtask

  task automatic test_reset();
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0 ||
          result[d] !== 128'h0) begin
        failures++;
        $display("FAIL reset dut%0d: in_ready=%b out_valid=%b busy=%b result=%h required 1 0 0 0",
                 d, in_ready[d], out_valid[d], busy[d], result[d]);
      end
    end
  endtask

  task automatic test_known_answers();
    logic [127:0] kst [6], kkey [6], kexp [6];
    logic         klast [6];
    kst   = '{128'h000102030405060708090a0b0c0d0e0f, {4{32'h8e4da1bc}}, {4{32'h9fdc589d}},
              {4{32'h01010101}}, 128'h0, 128'h0};
    kkey  = '{128'h0, 128'h0, 128'h0, 128'h0, {4{32'h8e4da1bc}}, {4{32'h8e4da1bc}}};
    klast = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    kexp  = '{128'h000d0a07_04010e0b_0805020f_0c090603, {4{32'hdb135345}}, {4{32'hf20a225c}},
              {4{32'h01010101}}, {4{32'hdb135345}}, {4{32'h8e4da1bc}}};
    for (int d = 0; d < NDUT; d++)
      for (int i = 0; i < 6; i++) run_txn(d, kst[i], kkey[i], klast[i], kexp[i]);
  endtask

  task automatic test_random();
    logic [127:0] st, key;
    logic         lst;
    for (int d = 0; d < NDUT; d++)
      for (int i = 0; i < 12; i++) begin
        st  = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        lst = 1'($urandom_range(0, 1));
        run_txn(d, st, key, lst, model(st, key, lst));
      end
  endtask

  task automatic test_back_to_back();
    logic [127:0] st1, key1, st2, key2, exp1, exp2;
    int n;
    for (int d = 0; d < NDUT; d++) begin
      st1 = {$urandom, $urandom, $urandom, $urandom};
      key1 = {$urandom, $urandom, $urandom, $urandom};
      st2 = {$urandom, $urandom, $urandom, $urandom};
      key2 = {$urandom, $urandom, $urandom, $urandom};
      exp1 = model(st1, key1, 1'b0);
      exp2 = model(st2, key2, 1'b0);
      accept(d, st1, key1, 1'b0);
      wait_out(d, n);
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #1;
        checks++;
        if (out_valid[d] !== 1'b1 || in_ready[d] !== 1'b0 || result[d] !== exp1) begin
          failures++;
          $display("FAIL hold dut%0d cyc%0d: out_valid=%b in_ready=%b result=%h required 1 0 %h",
                   d, c, out_valid[d], in_ready[d], result[d], exp1);
        end
      end
      out_ready[d] = 1'b1; in_valid[d] = 1'b1; state[d] = st2; roundkey[d] = key2;
      last[d] = 1'b0;
      #1;
      checks++;
      if (in_ready[d] !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready dut%0d: in_ready=%b required 1", d, in_ready[d]);
      end
      @(posedge clk); #1;
      in_valid[d] = 1'b0; out_ready[d] = 1'b0;
      checks++;
      if (out_valid[d] !== 1'b0 || busy[d] !== 1'b1) begin
        failures++;
        $display("FAIL b2b_busy dut%0d: out_valid=%b busy=%b required 0 1",
                 d, out_valid[d], busy[d]);
      end
      wait_out(d, n);
      checks++;
      if (n !== latency_of(d) || result[d] !== exp2) begin
        failures++;
        $display("FAIL b2b_second dut%0d: latency %0d result %h required %0d %h",
                 d, n, result[d], latency_of(d), exp2);
      end
      consume(d);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    accept(0, {4{32'h8e4da1bc}}, 128'h0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0 ||
        result[0] !== 128'h0) begin
      failures++;
      $display("FAIL reset_mid dut0: in_ready=%b out_valid=%b busy=%b result=%h required 1 0 0 0",
               in_ready[0], out_valid[0], busy[0], result[0]);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL reset_mid_quiet dut0: activity after reset, required none");
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b0; last[d] = 1'b0;
      state[d] = '0; roundkey[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_known_answers();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
